// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: blank pattern,
// scan FSM states and a counter-width helper.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    // Width of a counter that runs 0..div-1; never narrower than one bit.
    function automatic int cnt_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/hexto7segment.sv
// BCD to common-anode 7-segment decoder, segments {g..a} active low.
// Codes 10..15 are not BCD and decode to a dark digit.
module hexto7segment (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        case (hex)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits with
// frame-coherent display updates, anti-ghosting blanking and zero suppression.
module seven_seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 500,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int CNT_MAX = (BLANK_CYCLES > REFRESH_DIV) ? BLANK_CYCLES : REFRESH_DIV;
    localparam int CW      = cnt_width(CNT_MAX);
    localparam int IW      = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] BLANK_LAST   = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DIGITS - 1);

    state_e                         state_q, state_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           cnt_done, commit;

    logic [NUM_DIGITS-1:0][3:0]     staged_val_q, staged_val_d;
    logic [NUM_DIGITS-1:0]          staged_dp_q, staged_dp_d;
    logic                           pending_q, pending_d;
    logic [NUM_DIGITS-1:0][3:0]     shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]          shadow_dp_q, shadow_dp_d;

    logic [NUM_DIGITS-1:0]          supp;
    logic                           zero_above;
    logic [6:0]                     dec_seg;

    logic [NUM_DIGITS-1:0]          an_q, an_d;
    logic [6:0]                     seg_q, seg_d;
    logic                           dp_n_q, dp_n_d;

    // Scan FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BLANK;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Scan FSM: next state
    always_comb begin
        cnt_done = (state_q == ST_BLANK) ? (cnt_q == BLANK_LAST) : (cnt_q == REFRESH_LAST);
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_done) begin
            cnt_d = '0;
            if (state_q == ST_BLANK) begin
                state_d = ST_DRIVE;
            end else begin
                state_d = ST_BLANK;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
        end
        commit = (state_q == ST_DRIVE) && cnt_done && (idx_q == IDX_LAST);
    end

    // Staging and shadow: shadow only changes at the frame wrap, so one
    // frame never shows two different loads.
    always_comb begin
        staged_val_d = staged_val_q;
        staged_dp_d  = staged_dp_q;
        pending_d    = pending_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        if (commit && pending_q) begin
            shadow_val_d = staged_val_q;
            shadow_dp_d  = staged_dp_q;
            pending_d    = 1'b0;
        end
        if (load) begin
            staged_val_d = value;
            staged_dp_d  = dp_in;
            pending_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staged_val_q <= '0;
            staged_dp_q  <= '0;
            pending_q    <= 1'b0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
        end else begin
            staged_val_q <= staged_val_d;
            staged_dp_q  <= staged_dp_d;
            pending_q    <= pending_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
        end
    end

    // A digit above 0 is suppressed when it and every higher digit is a
    // plain zero with no decimal point.
    always_comb begin
        zero_above = 1'b1;
        supp       = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (shadow_val_q[i] == 4'd0) && !shadow_dp_q[i];
            supp[i]    = (LZ_SUPPRESS != 0) && zero_above;
        end
    end

    hexto7segment u_dec (
        .hex (shadow_val_q[idx_q]),
        .seg (dec_seg)
    );

    // Scan FSM: outputs, computed for the upcoming state so the registered
    // pins are valid from the first DRIVE cycle. idx does not move on
    // entry to DRIVE, so idx_q selects the digit.
    always_comb begin
        an_d   = '1;
        seg_d  = SEG_BLANK;
        dp_n_d = 1'b1;
        if (state_d == ST_DRIVE && digit_en[idx_q] && !supp[idx_q]) begin
            an_d[idx_q] = 1'b0;
            seg_d       = dec_seg;
            dp_n_d      = ~shadow_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q   <= '1;
            seg_q  <= SEG_BLANK;
            dp_n_q <= 1'b1;
        end else begin
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_n_q <= dp_n_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp_n = dp_n_q;

    // Held low while reset is asserted so the pulse lands in the first
    // cycle after release.
    assign frame_start = !rst && (state_q == ST_BLANK) && (idx_q == '0) && (cnt_q == '0);

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench: two DUTs (zero suppression off/on) checked cycle by
// cycle against per-frame expectations queued before each frame runs.
module tb_seven_seg_scan_ctrl;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0010000, SB = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = 4'hF;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dpn0, dpn1, fs0, fs1;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .LZ_SUPPRESS(0)) dut0 (
        .clk(clk), .rst(rst), .value(value), .load(load), .dp_in(dp_in), .digit_en(digit_en),
        .an(an0), .seg(seg0), .dp_n(dpn0), .frame_start(fs0));

    seven_seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .LZ_SUPPRESS(1)) dut1 (
        .clk(clk), .rst(rst), .value(value), .load(load), .dp_in(dp_in), .digit_en(digit_en),
        .an(an1), .seg(seg1), .dp_n(dpn1), .frame_start(fs1));

    typedef struct packed {
        logic [3:0][6:0] seg;
        logic [3:0]      dpn;
        logic [3:0]      on0;
        logic [3:0]      on1;
    } disp_t;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  en;
        disp_t       d;
    } vec_t;

    typedef struct {
        logic [12:0] e0;
        logic [12:0] e1;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic disp_t mk(input logic [6:0] s3, s2, s1, s0,
                                 input logic [3:0] dpn, on0, on1);
        disp_t r;
        r.seg = {s3, s2, s1, s0};
        r.dpn = dpn;
        r.on0 = on0;
        r.on1 = on1;
        return r;
    endfunction

    // Expected {an, seg, dp_n, frame_start} for cycle c of a 20-cycle frame.
    function automatic logic [12:0] slot(input disp_t e, input logic [3:0] on, input int c);
        int d = c / 5;
        logic fs = (c == 0);
        logic [3:0] an_e;
        if (c % 5 == 0 || !on[d]) return {4'hF, SB, 1'b1, fs};
        an_e = ~(4'b0001 << d);
        return {an_e, e.seg[d], e.dpn[d], fs};
    endfunction

    task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got an/seg/dpn/fs=%h want %h", nm, act, exp_v);
        end
    endtask

    task automatic run_frame(input string tag, input disp_t e, input int ncyc,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb,
                             input logic [3:0] ldp, input logic [3:0] nen);
        exp_t x;
        for (int c = 0; c < ncyc; c++) begin
            x.e0 = slot(e, e.on0, c);
            x.e1 = slot(e, e.on1, c);
            sbq.push_back(x);
        end
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            x = sbq.pop_front();
            chk($sformatf("%s c%0d lz0", tag, c), {an0, seg0, dpn0, fs0}, x.e0);
            chk($sformatf("%s c%0d lz1", tag, c), {an1, seg1, dpn1, fs1}, x.e1);
            load = 1'b0;
            if (c == la) begin load = 1'b1; value = va; dp_in = ldp; end
            if (c == lb) begin load = 1'b1; value = vb; dp_in = ldp; end
            if (c == 19) digit_en = nen;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        disp_t init, cur, d1111, d5678;
        vec_t  vt[7];

        init  = mk(S0, S0, S0, S0, 4'hF, 4'hF, 4'b0001);
        d1111 = mk(S1, S1, S1, S1, 4'hF, 4'hF, 4'hF);
        d5678 = mk(S5, S6, S7, S8, 4'hF, 4'hF, 4'hF);
        vt[0] = '{val: 16'h1234, dp: 4'b0000, en: 4'hF,    d: mk(S1, S2, S3, S4, 4'hF,    4'hF,    4'hF)};
        vt[1] = '{val: 16'h00A7, dp: 4'b0010, en: 4'b1011, d: mk(S0, S0, SB, S7, 4'b1101, 4'b1011, 4'b0011)};
        vt[2] = '{val: 16'h0050, dp: 4'b0000, en: 4'hF,    d: mk(S0, S0, S5, S0, 4'hF,    4'hF,    4'b0011)};
        vt[3] = '{val: 16'h9806, dp: 4'b1000, en: 4'hF,    d: mk(S9, S8, S0, S6, 4'b0111, 4'hF,    4'hF)};
        vt[4] = '{val: 16'h0000, dp: 4'b0100, en: 4'hF,    d: mk(S0, S0, S0, S0, 4'b1011, 4'hF,    4'b0111)};
        vt[5] = '{val: 16'hFFFF, dp: 4'b0000, en: 4'b0110, d: mk(SB, SB, SB, SB, 4'hF,    4'b0110, 4'b0110)};
        vt[6] = '{val: 16'h0001, dp: 4'b0000, en: 4'hF,    d: mk(S0, S0, S0, S1, 4'hF,    4'hF,    4'b0001)};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset lz0", {an0, seg0, dpn0, fs0}, {4'hF, SB, 1'b1, 1'b0});
        chk("reset lz1", {an1, seg1, dpn1, fs1}, {4'hF, SB, 1'b1, 1'b0});
        @(posedge clk);
        #1 rst = 1'b0;

        run_frame("boot", init, 20, -1, '0, -1, '0, '0, 4'hF);
        cur = init;

        // Each load lands mid-frame: that frame still shows the old value.
        for (int i = 0; i < 7; i++) begin
            run_frame($sformatf("v%0d", i), cur, 20, 7, vt[i].val, -1, '0, vt[i].dp, vt[i].en);
            cur = vt[i].d;
        end
        run_frame("v_last", cur, 20, -1, '0, -1, '0, '0, 4'hF);

        // Load in the exact commit cycle behind a pending load.
        run_frame("cc_a", cur,   20, 5, 16'h1111, 19, 16'h5678, 4'b0000, 4'hF);
        run_frame("cc_b", d1111, 20, -1, '0, -1, '0, '0, 4'hF);
        run_frame("cc_c", d5678, 20, -1, '0, -1, '0, '0, 4'hF);

        // Back-to-back loads within one frame: the last one wins.
        run_frame("b2b_a", d5678,   20, 3, 16'h1234, 10, 16'h9806, 4'b1000, 4'hF);
        run_frame("b2b_b", vt[3].d, 20, -1, '0, -1, '0, '0, 4'hF);

        // Asynchronous reset while digit 2 is being driven.
        run_frame("pre_rst", vt[3].d, 13, -1, '0, -1, '0, '0, 4'hF);
        rst = 1'b1;
        #1;
        chk("async_rst lz0", {an0, seg0, dpn0, fs0}, {4'hF, SB, 1'b1, 1'b0});
        chk("async_rst lz1", {an1, seg1, dpn1, fs1}, {4'hF, SB, 1'b1, 1'b0});
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        run_frame("post_rst", init, 20, -1, '0, -1, '0, '0, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
